// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the add/sub request sequencer:
//   - op_e    : request opcode (ADD/SUB/BOTH/NOP), 2-bit encoding on the pins
//   - state_e : sequencer FSM states
//   - req_t   : one queued request {a, b, op}
//   - DEPTH_DEFAULT, OPW (operand width), RESW (result width)
// ---------------------------------------------------------------------------
package addsub_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned OPW           = 4;
    localparam int unsigned RESW          = 5;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_BOTH = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        op_e            op;
    } req_t;

    function automatic logic op_has_add(input op_e op);
        return (op == OP_ADD) || (op == OP_BOTH);
    endfunction

    function automatic logic op_has_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_BOTH);
    endfunction

endpackage

// File: rtl/addsub_fifo.sv
// ---------------------------------------------------------------------------
// addsub_fifo
// Synchronous single-clock request FIFO with occupancy count.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   i_push       : write i_data (ignored when full)
//   i_data       : request to enqueue
//   i_pop        : drop head entry (ignored when empty)
//   o_data       : head entry (valid when !o_empty)
//   o_empty      : no entries held
//   o_count      : number of entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module addsub_fifo
    import addsub_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  req_t                     i_data,
    input  logic                     i_pop,
    output req_t                     o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    req_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign w_do_push = i_push && (r_count < CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/addsub_sequencer.sv
// ---------------------------------------------------------------------------
// addsub_sequencer
// Queues operand requests and drives them one at a time through an external
// add/sub stage (one-cycle registered latency), returning the results in
// acceptance order over a valid/ready handshake.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake; in_ready = FIFO not full
//   in_a, in_b, in_op     : operands and opcode (00 ADD, 01 SUB, 10 BOTH, 11 NOP)
//   a, b                  : operands driven to the add/sub stage
//   load, load1           : add-enable / sub-enable strobes (ISSUE only)
//   sum_in, sub_in        : registered a+b and |a-b| from the add/sub stage
//   out_valid/out_ready   : result handshake
//   out_sum, out_sub      : result values (0 where the op did not ask for it)
//   out_op                : opcode of the returned result
//   busy                  : FSM not idle
//   fifo_count            : requests waiting in the FIFO
// ---------------------------------------------------------------------------
module addsub_sequencer
    import addsub_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_a,
    input  logic [OPW-1:0]           in_b,
    input  logic [1:0]               in_op,
    output logic [OPW-1:0]           a,
    output logic [OPW-1:0]           b,
    output logic                     load,
    output logic                     load1,
    input  logic [RESW-1:0]          sum_in,
    input  logic [RESW-1:0]          sub_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RESW-1:0]          out_sum,
    output logic [RESW-1:0]          out_sub,
    output logic [1:0]               out_op,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e          r_state;
    state_e          w_next_state;

    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    op_e             r_op;

    logic [RESW-1:0] r_out_sum;
    logic [RESW-1:0] r_out_sub;
    op_e             r_out_op;

    req_t            w_push_req;
    req_t            w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [CW-1:0]   w_count;

    // ---------------- request FIFO ----------------
    always_comb begin
        w_push_req.a  = in_a;
        w_push_req.b  = in_b;
        w_push_req.op = op_e'(in_op);
    end

    assign in_ready = (w_count < CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == ST_IDLE) && !w_empty;

    addsub_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign fifo_count = w_count;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  w_next_state = ST_RESP;
            ST_RESP:  if (out_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load      = 1'b0;
        load1     = 1'b0;
        out_valid = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_ISSUE: begin
                load  = op_has_add(r_op);
                load1 = op_has_sub(r_op);
            end
            ST_RESP:  out_valid = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- operand registers ----------------
    // Loaded on the pop edge so a/b are already stable during ISSUE and
    // then hold until the next request is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= OP_ADD;
        end else if (w_pop) begin
            r_a  <= w_head.a;
            r_b  <= w_head.b;
            r_op <= w_head.op;
        end
    end

    assign a = r_a;
    assign b = r_b;

    // ---------------- result registers ----------------
    // The stage registers on the ISSUE->WAIT edge, so its outputs are
    // valid throughout WAIT and are captured on the WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_sum <= '0;
            r_out_sub <= '0;
            r_out_op  <= OP_ADD;
        end else if (r_state == ST_WAIT) begin
            r_out_sum <= op_has_add(r_op) ? sum_in : '0;
            r_out_sub <= op_has_sub(r_op) ? sub_in : '0;
            r_out_op  <= r_op;
        end
    end

    assign out_sum = r_out_sum;
    assign out_sub = r_out_sub;
    assign out_op  = r_out_op;

endmodule

// File: tb/tb_addsub_sequencer.sv
// ---------------------------------------------------------------------------
// tb_addsub_sequencer
// Directed bench for addsub_sequencer with a registered add/sub stage model.
// All stimulus is applied and all outputs sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_addsub_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic [3:0] a;
    logic [3:0] b;
    logic       load;
    logic       load1;
    logic [4:0] sum_in;
    logic [4:0] sub_in;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic [4:0] out_sub;
    logic [1:0] out_op;
    logic       busy;
    logic [2:0] fifo_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_sequencer #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .a          (a),
        .b          (b),
        .load       (load),
        .load1      (load1),
        .sum_in     (sum_in),
        .sub_in     (sub_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_sub    (out_sub),
        .out_op     (out_op),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Add/sub stage: one-cycle registered latency, shared reset.
    always @(posedge clk) begin
        if (reset) begin
            sum_in <= '0;
            sub_in <= '0;
        end else begin
            if (load)  sum_in <= {1'b0, a} + {1'b0, b};
            if (load1) sub_in <= (a >= b) ? ({1'b0, a} - {1'b0, b})
                                          : ({1'b0, b} - {1'b0, a});
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One request into an empty idle block, cycle-exact through E0..E4.
    task automatic run_op(input string t, input logic [3:0] va, input logic [3:0] vb,
                          input logic [1:0] vop, input int unsigned es, input int unsigned eu,
                          input int unsigned el, input int unsigned el1);
        in_a = va; in_b = vb; in_op = vop; in_valid = 1'b1; out_ready = 1'b1;
        check({t, "_in_ready"}, in_ready, 1);
        step();                                   // after E0: queued
        in_valid = 1'b0;
        check({t, "_cnt_e0"}, fifo_count, 1);
        check({t, "_busy_e0"}, busy, 0);
        check({t, "_valid_e0"}, out_valid, 0);
        step();                                   // after E1: ISSUE
        check({t, "_load"}, load, el);
        check({t, "_load1"}, load1, el1);
        check({t, "_a"}, a, va);
        check({t, "_b"}, b, vb);
        check({t, "_cnt_e1"}, fifo_count, 0);
        step();                                   // after E2: WAIT
        check({t, "_load_off"}, load, 0);
        check({t, "_load1_off"}, load1, 0);
        check({t, "_valid_e2"}, out_valid, 0);
        check({t, "_a_hold"}, a, va);
        step();                                   // after E3: RESP
        check({t, "_valid_e3"}, out_valid, 1);
        check({t, "_sum"}, out_sum, es);
        check({t, "_sub"}, out_sub, eu);
        check({t, "_op"}, out_op, vop);
        step();                                   // after E4: accepted
        check({t, "_valid_e4"}, out_valid, 0);
        check({t, "_busy_e4"}, busy, 0);
    endtask

    // Backpressure vectors; entry 5 must be refused.
    int unsigned bp_a  [6] = '{1, 10, 8, 7, 15, 0};
    int unsigned bp_b  [6] = '{2, 4, 3, 7, 14, 5};
    int unsigned bp_op [6] = '{0, 1, 2, 3, 0, 1};
    int unsigned bp_sum[5] = '{3, 0, 11, 0, 29};
    int unsigned bp_sub[5] = '{0, 6, 5, 0, 0};

    initial begin
        int unsigned acc;
        int unsigned last_cyc;
        int unsigned seen;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_cnt", fifo_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_load", load, 0);
        check("rst_load1", load1, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_sum", out_sum, 0);
        check("rst_sub", out_sub, 0);
        check("rst_op", out_op, 0);
        check("rst_busy", busy, 0);

        run_op("add",  4'd9,  4'd7,  2'b00, 16, 0, 1, 0);
        run_op("sub",  4'd3,  4'd12, 2'b01, 0,  9, 0, 1);
        run_op("both", 4'd15, 4'd15, 2'b10, 30, 0, 1, 1);
        run_op("nop",  4'd5,  4'd2,  2'b11, 0,  0, 0, 0);

        // Backpressure: six back-to-back offers with out_ready low.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_a = 4'(bp_a[i]); in_b = 4'(bp_b[i]); in_op = 2'(bp_op[i]);
            in_valid = 1'b1;
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 5);
        check("bp_in_ready", in_ready, 0);
        check("bp_cnt_full", fifo_count, 4);
        check("bp_held_valid", out_valid, 1);
        step();
        check("bp_held_sum", out_sum, bp_sum[0]);
        out_ready = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < 12 && !out_valid; w++) step();
            check($sformatf("bp_valid%0d", i), out_valid, 1);
            check($sformatf("bp_sum%0d", i), out_sum, bp_sum[i]);
            check($sformatf("bp_sub%0d", i), out_sub, bp_sub[i]);
            check($sformatf("bp_op%0d", i), out_op, bp_op[i]);
            if (i > 1) check($sformatf("bp_gap%0d", i), cyc - last_cyc, 4);
            last_cyc = cyc;
            step();
        end
        seen = 0;
        repeat (8) begin
            if (out_valid) seen++;
            step();
        end
        check("bp_no_extra", seen, 0);
        check("bp_cnt_drained", fifo_count, 0);

        // Reset during WAIT, with a simultaneous push offered.
        in_a = 4'd6; in_b = 4'd1; in_op = 2'b01; in_valid = 1'b1;
        step();                                   // E0
        in_valid = 1'b0;
        step();                                   // E1 ISSUE
        step();                                   // E2 WAIT
        reset = 1'b1; in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2; in_op = 2'b00;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("rw_valid", out_valid, 0);
        check("rw_cnt", fifo_count, 0);
        check("rw_load", load, 0);
        check("rw_load1", load1, 0);
        check("rw_busy", busy, 0);
        check("rw_sub", out_sub, 0);
        check("rw_in_ready", in_ready, 1);
        seen = 0;
        repeat (8) begin
            if (out_valid || load || load1) seen++;
            step();
        end
        check("rw_no_result", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_sequencer.md
ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  FIFO can accept a request.
REQ-006 SHALL have ports in_a, in_b  input  4 each  unsigned operands.
REQ-007 SHALL have port in_op  input  2  00 ADD, 01 SUB, 10 BOTH, 11 NOP.
REQ-008 SHALL have ports a, b  output  4 each  operands driven to the add/sub stage.
REQ-009 SHALL have ports load, load1  output  1 each  add-enable and sub-enable strobes to the add/sub stage.
REQ-010 SHALL have ports sum_in, sub_in  input  5 each  registered sum and |a-b| from the add/sub stage.
REQ-011 SHALL have ports out_valid  output  1, and out_ready  input  1  result handshake.
REQ-012 SHALL have ports out_sum, out_sub  output  5 each, and out_op  output  2  result and its opcode.
REQ-013 SHALL have ports busy  output  1 (state != IDLE) and fifo_count  output  $clog2(DEPTH)+1.

Function
REQ-014 SHALL push {in_a,in_b,in_op} when in_valid && in_ready; in_ready = (fifo_count < DEPTH), no push-through when full.
REQ-015 SHALL run FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-016 IDLE: if FIFO non-empty, pop head into a/b/op registers, go ISSUE; else stay; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-017 ISSUE: exactly one cycle; load=1 iff op in {ADD,BOTH}; load1=1 iff op in {SUB,BOTH}; NOP asserts neither.
REQ-018 load and load1 SHALL be 0 in every state except ISSUE; a/b SHALL hold the last issued values outside ISSUE.
REQ-019 WAIT: one cycle; at its ending edge capture out_sum = sum_in if op has ADD else 0, out_sub = sub_in if op has SUB else 0, out_op = op; go RESP.
REQ-020 RESP: out_valid=1, outputs stable until out_valid && out_ready; then IDLE.
REQ-021 Latency: request accepted at edge E0 into empty idle block SHALL give out_valid high after edge E3; sustained throughput one result per 4 cycles with out_ready=1.
REQ-022 Results SHALL be returned in acceptance order; no drops, no duplicates.
REQ-023 All arithmetic SHALL be unsigned; values pass through unmodified at 5 bits.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-025 On reset: state IDLE, FIFO emptied (fifo_count=0), a=b=0, load=load1=0, out_valid=0, out_sum=out_sub=0, out_op=00, in_ready=1 from next cycle.
REQ-026 Reset in any state SHALL abandon the in-flight operation with no result produced; reset SHALL dominate simultaneous push or handshake.

Structure
REQ-027 Package addsub_pkg SHALL hold the op enum (ADD/SUB/BOTH/NOP), FSM state enum, DEPTH_DEFAULT, and widths OPW=4, RESW=5.
REQ-028 FIFO SHALL be sub-module addsub_fifo (sync, single clock, count output); FSM and result registers SHALL be in addsub_sequencer.
REQ-029 Bench SHALL connect outputs to a model of the add/sub stage with one-cycle registered latency and the shared reset.

Verification
REQ-030 ADD a=9,b=7, out_ready=1 -> load pulses 1 cycle, load1=0, out_sum=16, out_sub=0, out_valid after E3.
REQ-031 SUB a=3,b=12 -> load1 only, out_sub=9, out_sum=0, out_op=01.
REQ-032 BOTH a=15,b=15 -> both strobes same cycle, out_sum=30, out_sub=0.
REQ-033 6 back-to-back requests, out_ready=0 -> 5 accepted, in_ready low, fifo_count=4; release out_ready -> 5 results in order.
REQ-034 reset asserted during WAIT -> next cycle out_valid=0, fifo_count=0, load=load1=0, no result ever emitted.
REQ-035 NOP a=5,b=2 -> no strobes, out_valid with out_sum=0, out_sub=0, out_op=11.
